// File: rtl/ctrl_pkg.sv
// Shared encodings and the execute-stage control bundle for the pipeline control path.
// Pure declarations: no logic, no latency.
package ctrl_pkg;

  localparam int ALUC_W = 3;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              alu_src;
    logic [1:0]        result_src;
    logic [ALUC_W-1:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/ctrl_pipeline_hazard_unit.sv
// Load-use stall, redirect flush and operand-forward selection.
// Purely combinational (zero latency); stalls are requested here, never absorbed.
module hazard_unit
  import ctrl_pkg::*;
#(
  parameter int RF_AW = 5
) (
  input  logic [RF_AW-1:0] rs1_d_i,
  input  logic [RF_AW-1:0] rs2_d_i,
  input  logic [RF_AW-1:0] rs1_e_i,
  input  logic [RF_AW-1:0] rs2_e_i,
  input  logic [RF_AW-1:0] rd_e_i,
  input  logic [1:0]       result_src_e_i,
  input  logic             branch_e_i,
  input  logic             jump_e_i,
  input  logic             zero_e_i,
  input  logic [RF_AW-1:0] rd_m_i,
  input  logic             reg_write_m_i,
  input  logic [RF_AW-1:0] rd_w_i,
  input  logic             reg_write_w_i,
  output logic             pc_src_e_o,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic [1:0]       forward_a_e_o,
  output logic [1:0]       forward_b_e_o
);

  logic lw_stall;

  // Memory stage wins over writeback: it holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [RF_AW-1:0] rs,
    input logic             rw_m,
    input logic [RF_AW-1:0] rd_m,
    input logic             rw_w,
    input logic [RF_AW-1:0] rd_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rw_m && (rd_m != '0) && (rs == rd_m)) begin
      sel = FWD_MEM;
    end else if (rw_w && (rd_w != '0) && (rs == rd_w)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign lw_stall = (result_src_e_i == RES_MEM) && (rd_e_i != '0) &&
                    ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i));

  assign pc_src_e_o = (branch_e_i & zero_e_i) | jump_e_i;

  assign stall_f_o = lw_stall;
  assign stall_d_o = lw_stall;
  assign flush_d_o = pc_src_e_o;
  assign flush_e_o = lw_stall | pc_src_e_o;

  assign forward_a_e_o = fwd_sel(rs1_e_i, reg_write_m_i, rd_m_i, reg_write_w_i, rd_w_i);
  assign forward_b_e_o = fwd_sel(rs2_e_i, reg_write_m_i, rd_m_i, reg_write_w_i, rd_w_i);

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-path pipeline registers D->E->M->W plus hazard unit; one cycle per stage.
// E capture is replaced by a bubble on FlushE; E->M and M->W always advance.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int RF_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ResultSrcD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [RF_AW-1:0]  Rs1D,
  input  logic [RF_AW-1:0]  Rs2D,
  input  logic [RF_AW-1:0]  RdD,
  input  logic              ZeroE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic [RF_AW-1:0]  Rs1E,
  output logic [RF_AW-1:0]  Rs2E,
  output logic [RF_AW-1:0]  RdE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [RF_AW-1:0]  RdM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [RF_AW-1:0]  RdW,
  output logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
);

  ctrl_t            ctrl_e_d, ctrl_e_q;
  logic [RF_AW-1:0] rs1_e_d, rs1_e_q;
  logic [RF_AW-1:0] rs2_e_d, rs2_e_q;
  logic [RF_AW-1:0] rd_e_d, rd_e_q;

  logic             reg_write_m_d, reg_write_m_q;
  logic             mem_write_m_d, mem_write_m_q;
  logic [1:0]       result_src_m_d, result_src_m_q;
  logic [RF_AW-1:0] rd_m_d, rd_m_q;

  logic             reg_write_w_d, reg_write_w_q;
  logic [1:0]       result_src_w_d, result_src_w_q;
  logic [RF_AW-1:0] rd_w_d, rd_w_q;

  // A flushed edge loads zeros, which also keeps X on the D inputs out of E.
  always_comb begin
    ctrl_e_d = '0;
    rs1_e_d  = '0;
    rs2_e_d  = '0;
    rd_e_d   = '0;
    if (!FlushE) begin
      ctrl_e_d.reg_write   = RegWriteD;
      ctrl_e_d.mem_write   = MemWriteD;
      ctrl_e_d.jump        = JumpD;
      ctrl_e_d.branch      = BranchD;
      ctrl_e_d.alu_src     = ALUSrcD;
      ctrl_e_d.result_src  = ResultSrcD;
      ctrl_e_d.alu_control = ALUControlD;
      rs1_e_d              = Rs1D;
      rs2_e_d              = Rs2D;
      rd_e_d               = RdD;
    end
  end

  assign reg_write_m_d  = ctrl_e_q.reg_write;
  assign mem_write_m_d  = ctrl_e_q.mem_write;
  assign result_src_m_d = ctrl_e_q.result_src;
  assign rd_m_d         = rd_e_q;

  assign reg_write_w_d  = reg_write_m_q;
  assign result_src_w_d = result_src_m_q;
  assign rd_w_d         = rd_m_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e_q <= '0;
      rs1_e_q  <= '0;
      rs2_e_q  <= '0;
      rd_e_q   <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      rs1_e_q  <= rs1_e_d;
      rs2_e_q  <= rs2_e_d;
      rd_e_q   <= rd_e_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= '0;
      rd_m_q         <= '0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
      rd_w_q         <= '0;
    end else begin
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      result_src_m_q <= result_src_m_d;
      rd_m_q         <= rd_m_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
    end
  end

  assign RegWriteE   = ctrl_e_q.reg_write;
  assign MemWriteE   = ctrl_e_q.mem_write;
  assign JumpE       = ctrl_e_q.jump;
  assign BranchE     = ctrl_e_q.branch;
  assign ALUSrcE     = ctrl_e_q.alu_src;
  assign ResultSrcE  = ctrl_e_q.result_src;
  assign ALUControlE = ctrl_e_q.alu_control;
  assign Rs1E        = rs1_e_q;
  assign Rs2E        = rs2_e_q;
  assign RdE         = rd_e_q;

  assign RegWriteM   = reg_write_m_q;
  assign MemWriteM   = mem_write_m_q;
  assign ResultSrcM  = result_src_m_q;
  assign RdM         = rd_m_q;

  assign RegWriteW   = reg_write_w_q;
  assign ResultSrcW  = result_src_w_q;
  assign RdW         = rd_w_q;

  hazard_unit #(
    .RF_AW(RF_AW)
  ) u_hazard (
    .rs1_d_i        (Rs1D),
    .rs2_d_i        (Rs2D),
    .rs1_e_i        (rs1_e_q),
    .rs2_e_i        (rs2_e_q),
    .rd_e_i         (rd_e_q),
    .result_src_e_i (ctrl_e_q.result_src),
    .branch_e_i     (ctrl_e_q.branch),
    .jump_e_i       (ctrl_e_q.jump),
    .zero_e_i       (ZeroE),
    .rd_m_i         (rd_m_q),
    .reg_write_m_i  (reg_write_m_q),
    .rd_w_i         (rd_w_q),
    .reg_write_w_i  (reg_write_w_q),
    .pc_src_e_o     (PCSrcE),
    .stall_f_o      (StallF),
    .stall_d_o      (StallD),
    .flush_d_o      (FlushD),
    .flush_e_o      (FlushE),
    .forward_a_e_o  (ForwardAE),
    .forward_b_e_o  (ForwardBE)
  );

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboarded bench for ctrl_pipeline: reference stage model, directed hazard cases, random stream.
module tb_ctrl_pipeline;

  typedef struct packed {
    logic       rw, mw, j, br, as;
    logic [1:0] rs;
    logic [2:0] ac;
    logic [4:0] rs1, rs2, rd;
  } ins_t;

  typedef struct packed {
    ins_t       e;
    logic [8:0] m;
    logic [7:0] w;
  } exp_t;

  logic       clk, reset;
  logic       RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       ZeroE;
  logic       RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic       RegWriteM, MemWriteM;
  logic [1:0] ResultSrcM;
  logic [4:0] RdM;
  logic       RegWriteW;
  logic [1:0] ResultSrcW;
  logic [4:0] RdW;
  logic       PCSrcE, StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;

  ctrl_pipeline #(.RF_AW(5)) dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  ins_t       obs_e;
  logic [8:0] obs_m;
  logic [7:0] obs_w;
  logic [8:0] obs_h;
  assign obs_e = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
                  Rs1E, Rs2E, RdE};
  assign obs_m = {RegWriteM, MemWriteM, ResultSrcM, RdM};
  assign obs_w = {RegWriteW, ResultSrcW, RdW};
  assign obs_h = {PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  ins_t mE;
  logic [8:0] mM;
  logic [7:0] mW;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic rw, input logic [1:0] rs, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic br = 1'b0, input logic j = 1'b0);
    ins_t t;
    t = '0;
    t.rw = rw; t.rs = rs; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.br = br; t.j = j;
    t.ac = 3'b010;
    return t;
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (mM[8] && mM[4:0] != 0 && rs == mM[4:0]) return 2'b10;
    if (mW[7] && mW[4:0] != 0 && rs == mW[4:0]) return 2'b01;
    return 2'b00;
  endfunction

  // Drive D and ZeroE, check hazard outputs against the model, queue the next-edge state.
  task automatic apply(input ins_t d, input logic z);
    logic lw, pc, fl;
    exp_t x;
    {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD, Rs1D, Rs2D, RdD} = d;
    ZeroE = z;
    #1;
    lw = (mE.rs == 2'b01) && (mE.rd != 0) && ((d.rs1 == mE.rd) || (d.rs2 == mE.rd));
    pc = (mE.br & z) | mE.j;
    fl = lw | pc;
    chk("hazard", {23'd0, obs_h}, {23'd0, pc, lw, lw, pc, fl, fwd_model(mE.rs1), fwd_model(mE.rs2)});
    x.e = fl ? '0 : d;
    x.m = {mE.rw, mE.mw, mE.rs, mE.rd};
    x.w = {mM[8], mM[6:5], mM[4:0]};
    sb.push_back(x);
  endtask

  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk("stage_E", {7'd0, obs_e}, {7'd0, x.e});
      chk("stage_M", {23'd0, obs_m}, {23'd0, x.m});
      chk("stage_W", {24'd0, obs_w}, {24'd0, x.w});
      mE = x.e; mM = x.m; mW = x.w;
    end
  endtask

  initial begin
    logic [31:0] r;
    ins_t d;
    ins_t first;
    reset = 1'b1;
    {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD, Rs1D, Rs2D, RdD} = 'x;
    ZeroE = 1'bx;
    mE = '0; mM = '0; mW = '0;
    #2;
    chk("rst_E", {7'd0, obs_e}, 32'd0);
    chk("rst_MW", {15'd0, obs_m, obs_w}, 32'd0);
    chk("rst_haz", {23'd0, obs_h}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // load-use
    apply(mk(1, 2'b01, 5, 1, 2), 0); tick();
    apply(mk(1, 2'b00, 3, 5, 6), 0);
    chk("lu_stallF", {31'd0, StallF}, 32'd1);
    chk("lu_stallD", {31'd0, StallD}, 32'd1);
    chk("lu_flushE", {31'd0, FlushE}, 32'd1);
    chk("lu_flushD", {31'd0, FlushD}, 32'd0);
    tick();
    chk("lu_bubble", {7'd0, obs_e}, 32'd0);
    chk("lu_release", {31'd0, StallF}, 32'd0);

    // forwarding priority M over W
    apply(mk(1, 2'b00, 7, 0, 0), 0); tick();
    apply(mk(1, 2'b00, 7, 0, 0), 0); tick();
    apply(mk(0, 2'b00, 0, 7, 0), 0); tick();
    chk("fwdA_mem", {30'd0, ForwardAE}, 32'd2);
    apply(mk(1, 2'b00, 7, 0, 0), 0); tick();
    apply(mk(0, 2'b00, 7, 0, 0), 0); tick();
    apply(mk(0, 2'b00, 0, 7, 0), 0); tick();
    chk("fwdA_wb", {30'd0, ForwardAE}, 32'd1);

    // taken and not-taken branch
    apply(mk(0, 2'b00, 0, 0, 0, 1'b1), 0); tick();
    apply(mk(0, 2'b00, 0, 0, 0), 1);
    chk("br_taken", {29'd0, PCSrcE, FlushD, FlushE}, 32'd7);
    tick();
    apply(mk(0, 2'b00, 0, 0, 0, 1'b1), 0); tick();
    apply(mk(0, 2'b00, 0, 0, 0), 0);
    chk("br_nottaken", {29'd0, PCSrcE, FlushD, FlushE}, 32'd0);
    tick();

    // x0 guard
    apply(mk(1, 2'b01, 0, 0, 0), 0); tick();
    apply(mk(0, 2'b00, 0, 0, 0), 0);
    chk("x0_nostall", {30'd0, StallF, FlushE}, 32'd0);
    tick();
    apply(mk(1, 2'b00, 0, 0, 0), 0); tick();
    apply(mk(0, 2'b00, 0, 0, 0), 0); tick();
    chk("x0_rwm", {31'd0, RegWriteM}, 32'd1);
    chk("x0_fwdB", {30'd0, ForwardBE}, 32'd0);

    // load-use together with a jump
    apply(mk(1, 2'b01, 5, 0, 0, 1'b0, 1'b1), 0); tick();
    apply(mk(0, 2'b00, 0, 5, 0), 0);
    chk("lu_jump", {28'd0, StallF, StallD, FlushD, FlushE}, 32'hF);
    tick();

    // asynchronous reset mid-stream
    apply(mk(1, 2'b00, 4, 0, 0), 0); tick();
    apply(mk(1, 2'b00, 4, 0, 0), 0); tick();
    chk("pre_rst_rwm", {31'd0, RegWriteM}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_rwm", {31'd0, RegWriteM}, 32'd0);
    chk("rst_async_E", {7'd0, obs_e}, 32'd0);
    chk("rst_async_MW", {15'd0, obs_m, obs_w}, 32'd0);
    chk("rst_async_haz", {23'd0, obs_h}, 32'd0);
    sb.delete();
    mE = '0; mM = '0; mW = '0;
    #1 reset = 1'b0;
    first = mk(1, 2'b10, 9, 1, 2);
    apply(first, 0); tick();
    chk("rst_first_E", {7'd0, obs_e}, {7'd0, first});

    // random stream over a small register window to make hazards frequent
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      d = r[24:0];
      d.rs1 = 5'($urandom_range(0, 3));
      d.rs2 = 5'($urandom_range(0, 3));
      d.rd  = 5'($urandom_range(0, 3));
      apply(d, 1'($urandom_range(0, 1)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
